// File: rtl/javk_bus_responder.sv
// JAVK CPU bus target: RAM window plus an I/O page with TX/RX byte FIFOs and a status register.
// Single driver of the CPU databus; reads are combinational, writes and pops land on the cycle-ending edge.
module javk_bus_responder #(
  parameter int          RAM_AW  = 12,
  parameter int          FIFO_AW = 2,
  parameter logic [7:0]  IO_PAGE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addrbus,
  input  logic        rw,
  inout  wire  [7:0]  databus,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int              RAM_DEPTH  = 1 << RAM_AW;
  localparam int              FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [15:0]     ADDR_TXD   = {IO_PAGE, 8'h00};
  localparam logic [15:0]     ADDR_RXD   = {IO_PAGE, 8'h01};
  localparam logic [15:0]     ADDR_STAT  = {IO_PAGE, 8'h02};
  localparam logic [FIFO_AW:0] PTR_ONE   = {{FIFO_AW{1'b0}}, 1'b1};

  logic [7:0] ram [RAM_DEPTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [7:0] rx_mem [FIFO_DEPTH];

  logic [FIFO_AW:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic             tx_oflow, rx_uflow, rx_oflow;

  logic       wr_en, rd_en, ram_sel;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_push_req, tx_push, tx_pop;
  logic       rx_push, rx_pop, rx_rd_req;
  logic       tx_oflow_set, rx_uflow_set, rx_oflow_set, stat_clr;
  logic [7:0] rdata;

  // Reset gates every bus side effect so a cycle interrupted by reset leaves no trace.
  assign wr_en   = rst & ~rw;
  assign rd_en   = rst & rw;
  assign ram_sel = (addrbus[15:RAM_AW] == '0);

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = (tx_wptr[FIFO_AW] != tx_rptr[FIFO_AW]) &&
                    (tx_wptr[FIFO_AW-1:0] == tx_rptr[FIFO_AW-1:0]);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = (rx_wptr[FIFO_AW] != rx_rptr[FIFO_AW]) &&
                    (rx_wptr[FIFO_AW-1:0] == rx_rptr[FIFO_AW-1:0]);

  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rptr[FIFO_AW-1:0]];
  assign rx_ready = ~rx_full;

  assign tx_push_req  = wr_en && !ram_sel && (addrbus == ADDR_TXD);
  assign tx_push      = tx_push_req && !tx_full;
  assign tx_pop       = rst && tx_valid && tx_ready;
  assign tx_oflow_set = tx_push_req && tx_full;

  assign rx_rd_req    = rd_en && !ram_sel && (addrbus == ADDR_RXD);
  assign rx_pop       = rx_rd_req && !rx_empty;
  assign rx_uflow_set = rx_rd_req && rx_empty;
  assign rx_push      = rst && rx_valid && rx_ready;
  assign rx_oflow_set = rst && rx_valid && rx_full;

  assign stat_clr = wr_en && !ram_sel && (addrbus == ADDR_STAT);

  // Storage arrays carry no reset; their contents are qualified by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en && ram_sel)
      ram[addrbus[RAM_AW-1:0]] <= databus;
    if (tx_push)
      tx_mem[tx_wptr[FIFO_AW-1:0]] <= databus;
    if (rx_push)
      rx_mem[rx_wptr[FIFO_AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wptr  <= '0;
      tx_rptr  <= '0;
      rx_wptr  <= '0;
      rx_rptr  <= '0;
      tx_oflow <= 1'b0;
      rx_uflow <= 1'b0;
      rx_oflow <= 1'b0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
      // A set event at the same edge as a STAT-write clear wins.
      tx_oflow <= tx_oflow_set | (tx_oflow & ~stat_clr);
      rx_uflow <= rx_uflow_set | (rx_uflow & ~stat_clr);
      rx_oflow <= rx_oflow_set | (rx_oflow & ~stat_clr);
    end
  end

  always_comb begin
    rdata = 8'hFF;
    if (ram_sel) begin
      rdata = ram[addrbus[RAM_AW-1:0]];
    end else begin
      case (addrbus)
        ADDR_TXD:  rdata = 8'h00;
        ADDR_RXD:  rdata = rx_empty ? 8'h00 : rx_mem[rx_rptr[FIFO_AW-1:0]];
        ADDR_STAT: rdata = {1'b0, rx_oflow, rx_uflow, tx_oflow,
                            rx_empty, rx_full, tx_empty, tx_full};
        default:   rdata = 8'hFF;
      endcase
    end
  end

  assign databus = rd_en ? rdata : 8'bzzzz_zzzz;

endmodule

// File: doc/javk_bus_responder.md
# javk_bus_responder

Memory-and-I/O responder on the JAVK CPU bus: the target end of the CPU's `addrbus`/`rw`/`databus` interface. It serves a RAM window plus an I/O page holding a transmit FIFO (CPU → external stream), a receive FIFO (external stream → CPU) and a status register. It replaces the ad-hoc memory model around the CPU and is the single device on the CPU databus.

## Interface

Parameters:
- `RAM_AW`, 12: RAM address width. RAM occupies 0x0000..2^RAM_AW−1. Legal range 8..15.
- `FIFO_AW`, 2: FIFO address width. Each FIFO holds 2^FIFO_AW entries.
- `IO_PAGE`, 8'hFF: high byte of the I/O page.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `addrbus`  in  16  CPU address.
- `rw`  in  1  1 = CPU read (responder drives `databus`); 0 = CPU write (CPU drives).
- `databus`  inout  8  bidirectional data.
- `tx_data`  out  8  head of TX FIFO.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_ready`  in  1  sink accepts `tx_data` at this edge.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  source offers `rx_data`.
- `rx_ready`  out  1  RX FIFO not full.

## Operation

- Bus cycle: the CPU presents `addrbus`/`rw` after a rising edge and holds them until the next rising edge, which ends the cycle.
- `databus` driving:
  - Driven when `rw`=1 and `rst`=1; high-Z otherwise, including whenever `rst`=0.
  - Read data is combinational from the current address.
- Address map:
  - 0x0000..2^RAM_AW−1: RAM. Read: asynchronous array read. Write: stored at the rising edge when `rw`=0. RAM contents are not reset.
  - {IO_PAGE,8'h00} TXD:
    - Write pushes `databus` into the TX FIFO.
    - Read returns 0x00 with no side effect.
  - {IO_PAGE,8'h01} RXD:
    - Read returns the RX FIFO head and pops it at the cycle-ending edge.
    - Read when empty returns 0x00, pops nothing and sets sticky `rx_uflow`.
    - Write is ignored.
  - {IO_PAGE,8'h02} STAT, read:
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty.
    - [4] tx_oflow, [5] rx_uflow, [6] rx_oflow, [7] 0.
  - STAT write (any value) clears bits 6:4.
  - All other addresses: reads return 0xFF; writes are ignored.
- TX FIFO:
  - A push when full is dropped and sets `tx_oflow`, even if a pop occurs at the same edge.
  - A pop occurs at an edge where `tx_valid`=1 and `tx_ready`=1.
  - A push and a pop at the same edge on a non-full FIFO both take effect, and the count is unchanged.
- RX FIFO:
  - A push occurs when `rx_valid`=1 and `rx_ready`=1.
  - `rx_oflow` sets when `rx_valid`=1 while full; the byte is lost.
  - A simultaneous CPU pop and stream push both take effect.
- If an overflow/underflow set event and a STAT-write clear happen at the same edge, the set wins.
- FIFO pointers are FIFO_AW+1 bits and wrap modulo 2^(FIFO_AW+1). Full means the pointer MSBs differ and the rest are equal; empty means the pointers are equal.

## Timing

- Reset (`rst` low, asynchronous):
  - Both FIFOs empty; all sticky flags 0; `databus` high-Z.
  - `tx_valid`=0; `rx_ready`=1; `tx_data`=0x00 while empty.
  - Reset mid-cycle aborts any pending write or pop.
  - Deassertion is synchronous to `clk` upstream; the first active edge is the one after `rst` rises.
- Read latency: zero cycles. Data is valid within the same bus cycle, before the ending edge.
- Write latency: one edge.
  - RAM readback is correct on the next cycle.
  - A TXD push makes `tx_valid` go to 1 right after the same edge.
- `tx_data` is the registered head; it updates right after the pop edge.
- Stream handshakes have no combinational path from `tx_ready` to `tx_valid` or from `rx_valid` to `rx_ready`.

## Test plan

- Reset, then write 0xA5 to 0x0123 and read 0x0123 → `databus`=0xA5. Read 0x2000 with RAM_AW=12 → 0xFF.
- Push 0x11,0x22,0x33,0x44 to TXD with `tx_ready`=0 → STAT=0x01. A fifth push 0x55 → STAT=0x11. Raise `tx_ready` → `tx_data` sequence 11,22,33,44, then `tx_valid`=0 and STAT=0x12.
- Stream 0x01..0x05 on RX with no CPU reads → only 0x01..0x04 are accepted and `rx_oflow` sets. RXD reads return 01,02,03,04, then 0x00 with `rx_uflow`. STAT=0x6A; writing STAT → 0x0A.
- With the TX FIFO holding 3 entries, push via TXD at the same edge as a `tx_ready` pop → count stays 3 and order is preserved.
- Assert `rst` during a TXD write cycle → no push occurs, `databus` goes high-Z immediately, and after release STAT=0x0A.
- Run 20 push/pop pairs through the TX FIFO → pointers wrap, data order is intact and no spurious full/empty is reported.
